// File: rtl/axi_sram_responder_if.sv
// AXI4 interface with the subset of channels used by the SRAM responder.
// Master drives m_* signals; the responder drives s_* signals.
interface axi4_interface #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 32
);
   logic                      m_aclk;
   logic                      m_aresetn;
   logic [AXI_ADDR_WIDTH-1:0] m_awaddr;
   logic [7:0]                m_awlen;
   logic [2:0]                m_awprot;
   logic                      m_awvalid;
   logic                      s_awready;
   logic [AXI_DATA_WIDTH-1:0] m_wdata;
   logic                      m_wlast;
   logic                      m_wvalid;
   logic                      s_wready;
   logic                      s_bvalid;
   logic                      m_bready;
   logic [AXI_ADDR_WIDTH-1:0] m_araddr;
   logic [7:0]                m_arlen;
   logic [2:0]                m_arprot;
   logic                      m_arvalid;
   logic                      s_arready;
   logic                      s_rvalid;
   logic [AXI_DATA_WIDTH-1:0] s_rdata;
   logic                      m_rready;

   modport slave (
      input  m_aclk, m_aresetn, m_awaddr, m_awlen, m_awprot, m_awvalid,
      input  m_wdata, m_wlast, m_wvalid, m_bready,
      input  m_araddr, m_arlen, m_arprot, m_arvalid, m_rready,
      output s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rdata
   );

   modport master (
      output m_aclk, m_aresetn, m_awaddr, m_awlen, m_awprot, m_awvalid,
      output m_wdata, m_wlast, m_wvalid, m_bready,
      output m_araddr, m_arlen, m_arprot, m_arvalid, m_rready,
      input  s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rdata
   );
endinterface

// File: rtl/axi_sram_responder.sv
// AXI4 slave terminating INCR bursts in an on-chip word-addressed SRAM, one transaction at a time.
// Define AXI_SRAM_BOUNDS_CHECK_EN to bounds-check each beat instead of wrapping the word index.
module axi_sram_responder #(
   parameter int MEM_WORDS       = 65536,
   parameter int WORD_ADDR_WIDTH = $clog2(MEM_WORDS),
   parameter int AXI_DATA_WIDTH  = 32
) (
   input logic          clk,
   input logic          reset_n,
   axi4_interface.slave axi_bus
);

`ifdef AXI_SRAM_BOUNDS_CHECK_EN
   localparam int PTR_W = 32;
   localparam logic [PTR_W-1:0] PTR_STEP = PTR_W'(4);
   localparam logic [32:0] LIMIT = 33'(MEM_WORDS) << 2;
`else
   localparam int PTR_W = WORD_ADDR_WIDTH;
   localparam logic [PTR_W-1:0] PTR_STEP = PTR_W'(1);
`endif

   typedef enum logic [1:0] {IDLE, WRITE_DATA, WRITE_RESP, READ_BURST} state_t;

   state_t                     state_q, state_d;
   logic                       prefer_write_q, prefer_write_d;
   logic [8:0]                 beats_q, beats_d;
   logic [PTR_W-1:0]           ptr_q, ptr_d;
   logic [AXI_DATA_WIDTH-1:0]  mem_q [MEM_WORDS];

   logic                       aw_grant, ar_grant, mem_we, in_range;
   logic [31:0]                addr_sel;
   logic [PTR_W-1:0]           start_ptr;
   logic [WORD_ADDR_WIDTH-1:0] mem_idx;

   assign aw_grant = (state_q == IDLE) && axi_bus.m_awvalid &&
                     (!axi_bus.m_arvalid || prefer_write_q);
   assign ar_grant = (state_q == IDLE) && axi_bus.m_arvalid && !aw_grant;
   assign addr_sel = aw_grant ? axi_bus.m_awaddr : axi_bus.m_araddr;

`ifdef AXI_SRAM_BOUNDS_CHECK_EN
   // Pointer is a full byte address so beats past the end are detected, not aliased
   assign start_ptr = {addr_sel[31:2], 2'b00};
   assign mem_idx   = ptr_q[WORD_ADDR_WIDTH+1:2];
   assign in_range  = ({1'b0, ptr_q} < LIMIT);
`else
   assign start_ptr = addr_sel[WORD_ADDR_WIDTH+1:2];
   assign mem_idx   = ptr_q;
   assign in_range  = 1'b1;
`endif

   assign mem_we = (state_q == WRITE_DATA) && axi_bus.m_wvalid && in_range;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         prefer_write_q <= 1'b0;
         beats_q        <= '0;
         ptr_q          <= '0;
      end else begin
         state_q        <= state_d;
         prefer_write_q <= prefer_write_d;
         beats_q        <= beats_d;
         ptr_q          <= ptr_d;
      end
   end

   // SRAM array carries no reset so partially written bursts survive one
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_idx] <= axi_bus.m_wdata;
      end
   end

   always_comb begin
      state_d        = state_q;
      prefer_write_d = prefer_write_q;
      beats_d        = beats_q;
      ptr_d          = ptr_q;
      case (state_q)
         IDLE: begin
            if (aw_grant) begin
               state_d        = WRITE_DATA;
               prefer_write_d = !prefer_write_q;
               ptr_d          = start_ptr;
               beats_d        = {1'b0, axi_bus.m_awlen} + 9'd1;
            end else if (ar_grant) begin
               state_d        = READ_BURST;
               prefer_write_d = !prefer_write_q;
               ptr_d          = start_ptr;
               beats_d        = {1'b0, axi_bus.m_arlen} + 9'd1;
            end
         end
         WRITE_DATA: begin
            if (axi_bus.m_wvalid) begin
               ptr_d   = ptr_q + PTR_STEP;
               beats_d = beats_q - 9'd1;
               if (beats_q == 9'd1) state_d = WRITE_RESP;
            end
         end
         WRITE_RESP: begin
            if (axi_bus.m_bready) state_d = IDLE;
         end
         READ_BURST: begin
            if (axi_bus.m_rready) begin
               ptr_d   = ptr_q + PTR_STEP;
               beats_d = beats_q - 9'd1;
               if (beats_q == 9'd1) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      axi_bus.s_awready = reset_n && aw_grant;
      axi_bus.s_arready = reset_n && ar_grant;
      axi_bus.s_wready  = (state_q == WRITE_DATA);
      axi_bus.s_bvalid  = (state_q == WRITE_RESP);
      axi_bus.s_rvalid  = (state_q == READ_BURST);
      axi_bus.s_rdata   = '0;
      if (state_q == READ_BURST) begin
         axi_bus.s_rdata = in_range ? mem_q[mem_idx] : AXI_DATA_WIDTH'(32'hDEADBEEF);
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (reset_n && state_q == WRITE_DATA && axi_bus.m_wvalid) begin
         assert (axi_bus.m_wlast == (beats_q == 9'd1));
      end
   end
`endif

endmodule

// File: tb/tb_axi_sram_responder.sv
// Randomized self-checking bench for axi_sram_responder against an address-level SRAM model.
// Expectations follow AXI_SRAM_BOUNDS_CHECK_EN when it is defined for the build.
module tb_axi_sram_responder;
   localparam int MW = 16;

   logic clk = 1'b0;
   logic reset_n;
   int   vectors = 0;
   int   miscompares = 0;

   axi4_interface bus ();

   axi_sram_responder #(.MEM_WORDS(MW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .axi_bus (bus)
   );

   always #5 clk = ~clk;
   assign bus.m_aclk    = clk;
   assign bus.m_aresetn = reset_n;
   assign bus.m_awprot  = 3'b000;
   assign bus.m_arprot  = 3'b000;

   // Reference model: byte-addressed SRAM, plus the address-grant preference bit
   logic [31:0] model_mem [MW];
   bit          model_pw;
   logic [31:0] wbuf [256];

   function automatic logic [31:0] beat_addr(input logic [31:0] base, input int i);
      return {base[31:2], 2'b00} + 32'(4 * i);
   endfunction

   function automatic bit addr_ok(input logic [31:0] a);
`ifdef AXI_SRAM_BOUNDS_CHECK_EN
      return a < 32'(MW * 4);
`else
      return 1'b1;
`endif
   endfunction

   function automatic int word_of(input logic [31:0] a);
      return int'((a >> 2) % MW);
   endfunction

   function automatic logic [31:0] expect_read(input logic [31:0] a);
      return addr_ok(a) ? model_mem[word_of(a)] : 32'hDEADBEEF;
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d);
      if (addr_ok(a)) model_mem[word_of(a)] = d;
   endtask

   task automatic idle_inputs();
      bus.m_awvalid = 0; bus.m_arvalid = 0; bus.m_wvalid = 0; bus.m_wlast = 0;
      bus.m_bready = 0; bus.m_rready = 0;
      bus.m_awaddr = 0; bus.m_araddr = 0; bus.m_awlen = 0; bus.m_arlen = 0; bus.m_wdata = 0;
   endtask

   // gap: 0 none, 1 wvalid low every other cycle, 2 random; bdelay: cycles before bready
   task automatic do_write(input logic [31:0] addr, input int len, input int gap,
                           input int bdelay, input string tag);
      int i = 0;
      int cyc = 0;
      bit wv;
      bus.m_awaddr = addr; bus.m_awlen = 8'(len); bus.m_awvalid = 1;
      @(negedge clk);
      vectors++;
      if (bus.s_awready !== 1'b1) begin
         miscompares++; $display("FAIL %s awready: got %b expected 1", tag, bus.s_awready);
      end
      @(posedge clk); #1;
      bus.m_awvalid = 0; model_pw = !model_pw;
      while (i <= len && cyc < 1000) begin
         case (gap)
            0: wv = 1'b1;
            1: wv = (cyc % 2 == 0);
            default: wv = ($urandom_range(0, 3) != 0);
         endcase
         bus.m_wvalid = wv; bus.m_wdata = wbuf[i]; bus.m_wlast = (i == len);
         @(negedge clk);
         vectors++;
         if (bus.s_wready !== 1'b1 || bus.s_bvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s wready beat %0d: got wready=%b bvalid=%b expected 1/0",
                     tag, i, bus.s_wready, bus.s_bvalid);
         end
         @(posedge clk); #1;
         if (wv) begin
            model_write(beat_addr(addr, i), wbuf[i]);
            i++;
         end
         cyc++;
      end
      bus.m_wvalid = 0; bus.m_wlast = 0;
      for (int k = 0; k <= bdelay; k++) begin
         bus.m_bready = (k == bdelay);
         @(negedge clk);
         vectors++;
         if (bus.s_bvalid !== 1'b1 || bus.s_wready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s bvalid: got bvalid=%b wready=%b expected 1/0",
                     tag, bus.s_bvalid, bus.s_wready);
         end
         @(posedge clk); #1;
      end
      bus.m_bready = 0;
      @(negedge clk);
      vectors++;
      if (bus.s_bvalid !== 1'b0) begin
         miscompares++; $display("FAIL %s bvalid_drop: got %b expected 0", tag, bus.s_bvalid);
      end
      @(posedge clk); #1;
   endtask

   // mode: 0 rready always high, 1 pattern 1,0,0,1,1,0,1 repeating, 2 random
   task automatic do_read(input logic [31:0] addr, input int len, input int mode,
                          input string tag);
      int i = 0;
      int cyc = 0;
      bit rr;
      logic [6:0] pat = 7'b1011001;
      logic [31:0] exp_d;
      bus.m_araddr = addr; bus.m_arlen = 8'(len); bus.m_arvalid = 1;
      @(negedge clk);
      vectors++;
      if (bus.s_arready !== 1'b1) begin
         miscompares++; $display("FAIL %s arready: got %b expected 1", tag, bus.s_arready);
      end
      @(posedge clk); #1;
      bus.m_arvalid = 0; model_pw = !model_pw;
      while (i <= len && cyc < 1000) begin
         case (mode)
            0: rr = 1'b1;
            1: rr = pat[cyc % 7];
            default: rr = 1'($urandom_range(0, 1));
         endcase
         bus.m_rready = rr;
         exp_d = expect_read(beat_addr(addr, i));
         @(negedge clk);
         vectors++;
         if (bus.s_rvalid !== 1'b1 || bus.s_rdata !== exp_d) begin
            miscompares++;
            $display("FAIL %s rdata beat %0d: got rvalid=%b data=%h expected 1/%h",
                     tag, i, bus.s_rvalid, bus.s_rdata, exp_d);
         end
         @(posedge clk); #1;
         if (rr) i++;
         cyc++;
      end
      bus.m_rready = 0;
      @(negedge clk);
      vectors++;
      if (bus.s_rvalid !== 1'b0 || bus.s_rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL %s read_end: got rvalid=%b data=%h expected 0/0",
                  tag, bus.s_rvalid, bus.s_rdata);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset_n = 0;
      bus.m_awvalid = 1; bus.m_arvalid = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({bus.s_awready, bus.s_arready, bus.s_wready, bus.s_bvalid, bus.s_rvalid} !== 5'b0 ||
          bus.s_rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: got aw=%b ar=%b w=%b b=%b r=%b data=%h expected all 0",
                  bus.s_awready, bus.s_arready, bus.s_wready, bus.s_bvalid, bus.s_rvalid,
                  bus.s_rdata);
      end
      bus.m_awvalid = 0; bus.m_arvalid = 0;
      @(posedge clk); #1;
      reset_n = 1; model_pw = 0;
      bus.m_awvalid = 1;
      #1;
      vectors++;
      if (bus.s_awready !== 1'b1) begin
         miscompares++; $display("FAIL reset_zero_wait: got awready=%b expected 1", bus.s_awready);
      end
      bus.m_awvalid = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_init();
      for (int i = 0; i < MW; i++) wbuf[i] = $urandom;
      do_write(32'h0, MW - 1, 0, 0, "init_wr");
      do_read(32'h0, MW - 1, 0, "init_rd");
   endtask

   task automatic test_arbitration();
      logic [31:0] wd = $urandom;
      reset_n = 0;
      @(posedge clk); #1;
      reset_n = 1; model_pw = 0;
      for (int round = 0; round < 3; round++) begin
         bus.m_awaddr = 32'h8; bus.m_awlen = 0; bus.m_araddr = 32'h8; bus.m_arlen = 0;
         bus.m_awvalid = 1; bus.m_arvalid = 1;
         @(negedge clk);
         vectors++;
         if (bus.s_awready !== model_pw || bus.s_arready !== !model_pw) begin
            miscompares++;
            $display("FAIL arb_round%0d: got awready=%b arready=%b expected %b/%b",
                     round, bus.s_awready, bus.s_arready, model_pw, !model_pw);
         end
         @(posedge clk); #1;
         bus.m_awvalid = 0; bus.m_arvalid = 0;
         if (model_pw) begin
            model_pw = 0;
            bus.m_wvalid = 1; bus.m_wlast = 1; bus.m_wdata = wd;
            @(posedge clk); #1;
            model_write(32'h8, wd);
            bus.m_wvalid = 0; bus.m_wlast = 0; bus.m_bready = 1;
            @(negedge clk);
            vectors++;
            if (bus.s_bvalid !== 1'b1) begin
               miscompares++; $display("FAIL arb_bvalid: got %b expected 1", bus.s_bvalid);
            end
            @(posedge clk); #1;
            bus.m_bready = 0;
         end else begin
            model_pw = 1;
            bus.m_rready = 1;
            @(negedge clk);
            vectors++;
            if (bus.s_rdata !== expect_read(32'h8)) begin
               miscompares++;
               $display("FAIL arb_rdata: got %h expected %h", bus.s_rdata, expect_read(32'h8));
            end
            @(posedge clk); #1;
            bus.m_rready = 0;
         end
      end
   endtask

   task automatic test_single();
      wbuf[0] = 32'h12345678;
      do_write(32'h100, 0, 0, 0, "single_wr");
      do_read(32'h100, 0, 0, "single_rd");
   endtask

   task automatic test_write_gaps();
      for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
      do_write(32'h40, 3, 1, 0, "gap_wr40");
      do_read(32'h40, 3, 0, "gap_rd40");
      do_write(32'h20, 3, 1, 2, "gap_wr20");
      do_read(32'h20, 3, 0, "gap_rd20");
   endtask

   task automatic test_backpressure();
      do_read(32'h20, 3, 1, "bp_rd");
   endtask

   task automatic test_bounds();
      wbuf[0] = 32'hA5A55A5A;
      do_write(32'h40, 0, 0, 0, "bnd_wr40");
      do_read(32'h40, 0, 0, "bnd_rd40");
      do_read(32'h0, 0, 0, "bnd_rd0");
      wbuf[0] = 32'h0BADF00D; wbuf[1] = 32'hFEEDFACE;
      do_write(32'h3C, 1, 0, 0, "bnd_wr3c");
      do_read(32'h3C, 1, 0, "bnd_rd3c");
   endtask

   task automatic test_reset_mid_burst();
      for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
      bus.m_awaddr = 32'h10; bus.m_awlen = 7; bus.m_awvalid = 1;
      @(posedge clk); #1;
      bus.m_awvalid = 0; model_pw = !model_pw;
      for (int i = 0; i < 2; i++) begin
         bus.m_wvalid = 1; bus.m_wdata = wbuf[i]; bus.m_wlast = 0;
         @(posedge clk); #1;
         model_write(beat_addr(32'h10, i), wbuf[i]);
      end
      bus.m_wdata = wbuf[2]; bus.m_awvalid = 1; bus.m_arvalid = 1;
      #2 reset_n = 0;
      #1;
      vectors++;
      if ({bus.s_awready, bus.s_arready, bus.s_wready, bus.s_bvalid, bus.s_rvalid} !== 5'b0 ||
          bus.s_rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL midburst_reset: got aw=%b ar=%b w=%b b=%b r=%b expected all 0",
                  bus.s_awready, bus.s_arready, bus.s_wready, bus.s_bvalid, bus.s_rvalid);
      end
      idle_inputs();
      @(posedge clk); #1;
      reset_n = 1; model_pw = 0;
      do_read(32'h10, 7, 0, "midburst_rd");
   endtask

   task automatic test_random();
      logic [31:0] a;
      int len;
      for (int n = 0; n < 20; n++) begin
         case ($urandom_range(0, 4))
            0: a = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
            1: a = 32'($urandom_range(0, 255));
            default: a = 32'($urandom_range(0, 63));
         endcase
         len = $urandom_range(0, 15);
         for (int i = 0; i <= len; i++) wbuf[i] = $urandom;
         do_write(a, len, $urandom_range(0, 2), $urandom_range(0, 2), "rnd_wr");
         do_read(a, len, $urandom_range(0, 2), "rnd_rd");
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_init();
      test_arbitration();
      test_single();
      test_write_gaps();
      test_backpressure();
      test_bounds();
      test_reset_mid_burst();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
